priv_exp_gen: RTL
=================

PRIV_EXP_GEN -- requirements
Module: priv_exp_gen

Interface
REQ-001 SHALL have parameter HALF_KEY_LENGTH, default 16, half of the RSA modulus width.
REQ-002 SHALL have parameter e_WIDTH, default 3, width of public exponent e.
REQ-003 SHALL use local width W = 2*HALF_KEY_LENGTH and accumulator width AW = W + e_WIDTH.
REQ-004 clk  input  1  rising-edge clock.
REQ-005 rst  input  1  reset, synchronous, active-low.
REQ-006 start  input  1  one-cycle request; f_n and e are sampled on the same edge.
REQ-007 f_n  input  W  Euler totient from the GCD stage, (p1-1)(p2-1).
REQ-008 e  input  e_WIDTH  public exponent.
REQ-009 d  output  W  private exponent; d*e mod f_n = 1 when valid=1.
REQ-010 valid  output  1  d is a correct inverse; meaningful only while ready=1.
REQ-011 ready  output  1  result available; held until the next accepted start or reset.
REQ-012 busy  output  1  high in LOAD-to-CHECK states; start is ignored while high.

Function
REQ-013 SHALL compute d = (1 + k*f_n)/e for the smallest k in 1..e-1 where (1 + k*f_n) mod e = 0.
REQ-014 SHALL implement FSM states IDLE, DIV, CHECK, DONE; unreachable encodings SHALL behave as IDLE.
REQ-015 IDLE/DONE + start: latch f_n, e; set k=1, acc=f_n+1 (AW bits, zero-extended); clear ready, valid; go to DIV.
REQ-016 If start is accepted with e<2 or f_n=0, the block SHALL go directly to DONE: ready=1, valid=0, d=0.
REQ-017 DIV SHALL run an AW-cycle restoring division of acc by e, producing one quotient bit per cycle, MSB first, then go to CHECK.
REQ-018 CHECK, remainder=0: d=quotient[W-1:0], valid=1, ready=1, go to DONE.
REQ-019 CHECK, remainder!=0 and k+1=e: d=0, valid=0, ready=1, go to DONE.
REQ-020 CHECK, otherwise: k=k+1, acc=acc+f_n (no overflow in AW bits), go to DIV.
REQ-021 Latency: ready SHALL rise k*(AW+1) edges after the edge that accepts start (1 edge for the REQ-016 case).
REQ-022 busy SHALL be 1 in DIV and CHECK and 0 in IDLE and DONE.
REQ-023 d, valid and ready SHALL change only on entry to DONE or on an accepted start.
REQ-024 The latched f_n and e SHALL be used for the whole operation; input changes after acceptance have no effect.
REQ-025 Start pulses during DIV/CHECK SHALL be dropped, not queued.

Reset
REQ-026 With rst=0 at an edge: state=IDLE, d=0, valid=0, ready=0, busy=0, and k, acc, quotient, remainder and the cycle counter cleared.
REQ-027 Reset SHALL override start and SHALL abort any operation in progress, with no partial result visible.

Verification (HALF_KEY_LENGTH=16, e_WIDTH=3, AW=35; one iteration = 36 cycles)
REQ-028 f_n=40, e=3 -> ready after 72 edges, valid=1, d=27.
REQ-029 f_n=60, e=7 -> ready after 180 edges, valid=1, d=43.
REQ-030 f_n=40, e=5 -> ready after 144 edges, valid=0, d=0.
REQ-031 e=1, f_n=40 -> ready after 1 edge, valid=0, d=0, busy never 1.
REQ-032 start f_n=40, e=3, then a second start with f_n=60, e=7 at edge 10 -> second start ignored, d=27 at edge 72.
REQ-033 rst=0 at edge 20 of f_n=60, e=7 -> all outputs 0 next edge; a fresh start then gives d=43 after 180 edges.

Source files
------------

// File: rtl/priv_exp_gen_if.sv
// Request/result bundle for the private-exponent generator.
// The requester drives start/f_n/e and the generator returns d/valid/ready/busy.
interface priv_exp_gen_if #(
  parameter int HALF_KEY_LENGTH = 16,
  parameter int e_WIDTH         = 3
);
  logic                           start;
  logic [2*HALF_KEY_LENGTH-1:0]   f_n;
  logic [e_WIDTH-1:0]             e;
  logic [2*HALF_KEY_LENGTH-1:0]   d;
  logic                           valid;
  logic                           ready;
  logic                           busy;

  modport master (output start, f_n, e, input d, valid, ready, busy);
  modport slave  (input start, f_n, e, output d, valid, ready, busy);
endinterface

// File: rtl/priv_exp_gen.sv
// RSA private exponent generator: d = (1 + k*f_n) / e for the smallest k in 1..e-1
// that divides exactly. Each candidate is tested with an AW-cycle restoring divider
// followed by one CHECK cycle, so candidate k completes k*(AW+1) edges after start.
module priv_exp_gen #(
  parameter int HALF_KEY_LENGTH = 16,
  parameter int e_WIDTH         = 3
) (
  input  logic           clk,
  input  logic           rst,
  priv_exp_gen_if.slave  bus
);
  localparam int W  = 2 * HALF_KEY_LENGTH;
  localparam int AW = W + e_WIDTH;
  localparam int CW = $clog2(AW + 1);

  typedef enum logic [1:0] {S_IDLE, S_DIV, S_CHECK, S_DONE} state_t;

  state_t             state_q;
  logic [W-1:0]       fn_q;
  logic [e_WIDTH-1:0] e_q;
  logic [e_WIDTH-1:0] k_q;
  logic [AW-1:0]      acc_q;
  logic [AW-1:0]      shift_q;   // dividend bits still to be consumed, MSB first
  logic [W-1:0]       quo_q;     // quotient always fits in W bits since e >= 2
  logic [e_WIDTH-1:0] rem_q;
  logic [CW-1:0]      cnt_q;
  logic [W-1:0]       d_q;
  logic               valid_q;
  logic               ready_q;
  logic               busy_q;

  // One restoring-division step plus the next candidate numerator
  logic [e_WIDTH:0]   trial_d;
  logic               trial_ge_d;
  logic [e_WIDTH-1:0] rem_d;
  logic [AW-1:0]      acc_d;
  logic [e_WIDTH:0]   k_inc_d;
  logic               degenerate_d;

  // Combinational datapath for the divider step and the accept decision
  always_comb begin
    trial_d      = {rem_q, shift_q[AW-1]};
    trial_ge_d   = (trial_d >= {1'b0, e_q});
    // The true difference is below e, so modulo-2^e_WIDTH arithmetic is exact
    rem_d        = trial_ge_d ? (trial_d[e_WIDTH-1:0] - e_q) : trial_d[e_WIDTH-1:0];
    acc_d        = acc_q + AW'(fn_q);
    k_inc_d      = {1'b0, k_q} + 1'b1;
    degenerate_d = (bus.e < e_WIDTH'(2)) || (bus.f_n == '0);
  end

  // Control FSM and datapath registers; every output is registered
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= S_IDLE;
      fn_q    <= '0;
      e_q     <= '0;
      k_q     <= '0;
      acc_q   <= '0;
      shift_q <= '0;
      quo_q   <= '0;
      rem_q   <= '0;
      cnt_q   <= '0;
      d_q     <= '0;
      valid_q <= 1'b0;
      ready_q <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      case (state_q)
        S_DIV: begin
          shift_q <= {shift_q[AW-2:0], 1'b0};
          quo_q   <= {quo_q[W-2:0], trial_ge_d};
          rem_q   <= rem_d;
          cnt_q   <= cnt_q + 1'b1;
          if (cnt_q == CW'(AW - 1)) begin
            state_q <= S_CHECK;
          end
        end

        S_CHECK: begin
          if (rem_q == '0) begin
            d_q     <= quo_q;
            valid_q <= 1'b1;
            ready_q <= 1'b1;
            busy_q  <= 1'b0;
            state_q <= S_DONE;
          end else if (k_inc_d == {1'b0, e_q}) begin
            d_q     <= '0;
            valid_q <= 1'b0;
            ready_q <= 1'b1;
            busy_q  <= 1'b0;
            state_q <= S_DONE;
          end else begin
            // Next candidate: numerator grows by f_n, divider restarts
            k_q     <= k_inc_d[e_WIDTH-1:0];
            acc_q   <= acc_d;
            shift_q <= acc_d;
            quo_q   <= '0;
            rem_q   <= '0;
            cnt_q   <= '0;
            state_q <= S_DIV;
          end
        end

        // IDLE, DONE and any stray encoding all wait for a new request
        default: begin
          if (bus.start) begin
            fn_q    <= bus.f_n;
            e_q     <= bus.e;
            k_q     <= e_WIDTH'(1);
            acc_q   <= AW'(bus.f_n) + 1'b1;
            shift_q <= AW'(bus.f_n) + 1'b1;
            quo_q   <= '0;
            rem_q   <= '0;
            cnt_q   <= '0;
            d_q     <= '0;
            valid_q <= 1'b0;
            if (degenerate_d) begin
              // No inverse can exist; report an invalid result straight away
              ready_q <= 1'b1;
              busy_q  <= 1'b0;
              state_q <= S_DONE;
            end else begin
              ready_q <= 1'b0;
              busy_q  <= 1'b1;
              state_q <= S_DIV;
            end
          end
        end
      endcase
    end
  end

  assign bus.d     = d_q;
  assign bus.valid = valid_q;
  assign bus.ready = ready_q;
  assign bus.busy  = busy_q;

endmodule
